// File: rtl/spi_mc_pkg.sv
// Shared types and constants for the multi-endpoint SPI master.
// The optional self-test loopback is enabled by defining SPI_LOOPBACK_EN.
package spi_mc_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    XFER  = 3'd2,
    WAIT  = 3'd3,
    TRAIL = 3'd4
  } state_t;

  // Mode constants, packed as {cpol, cpha}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  function automatic int cs_sel_w(input int num_cs);
    return (num_cs > 1) ? $clog2(num_cs) : 1;
  endfunction

endpackage

// File: rtl/spi_master_mc_if.sv
// Word-level bus between the register/DMA side and the SPI master.
// master = word producer/consumer, slave = the SPI master block.
interface spi_master_mc_if
  import spi_mc_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int NUM_CS = 4
) ();

  localparam int CS_SEL_W = cs_sel_w(NUM_CS);

  // A word moves on a clock edge where tx_valid && tx_ready; tx_data, tx_last and
  // cs_sel must be stable while tx_valid waits. rx_valid is a one-cycle pulse with
  // no backpressure.
  logic                tx_valid;
  logic                tx_ready;
  logic [DWIDTH-1:0]   tx_data;
  logic                tx_last;
  logic [CS_SEL_W-1:0] cs_sel;
  logic                rx_valid;
  logic [DWIDTH-1:0]   rx_data;

  modport master (
    output tx_valid, tx_data, tx_last, cs_sel,
    input  tx_ready, rx_valid, rx_data
  );

  modport slave (
    input  tx_valid, tx_data, tx_last, cs_sel,
    output tx_ready, rx_valid, rx_data
  );

endinterface

// File: rtl/spi_mc_clkgen.sv
// SCLK generator: half-period divider, tick and leading/trailing edge strobes.
// Outside a transfer sclk follows the supplied idle level.
module spi_mc_clkgen #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 toggle,
  input  logic                 cpol,
  input  logic [DIV_WIDTH-1:0] clk_div,
  output logic                 tick,
  output logic                 lead,
  output logic                 trail,
  output logic                 sclk
);

  logic [DIV_WIDTH-1:0] cnt;

  assign tick  = en && (cnt == clk_div);
  assign lead  = tick && toggle && (sclk == cpol);
  assign trail = tick && toggle && (sclk != cpol);

  always_ff @(posedge clk) begin
    if (rst || !en || tick) cnt <= '0;
    else                    cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)         sclk <= 1'b0;
    else if (!toggle) sclk <= cpol;
    else if (tick)    sclk <= ~sclk;
  end

endmodule

// File: rtl/spi_master_mc.sv
// SPI master with per-frame chip select, all four modes and selectable bit order.
// Define SPI_LOOPBACK_EN to add the loopback self-test input.
module spi_master_mc
  import spi_mc_pkg::*;
#(
  parameter int DWIDTH    = 8,
  parameter int NUM_CS    = 4,
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  spi_master_mc_if.slave       bus,
  input  logic                 cpol,
  input  logic                 cpha,
  input  logic                 lsb_first,
  input  logic [DIV_WIDTH-1:0] clk_div,
`ifdef SPI_LOOPBACK_EN
  input  logic                 loopback,
`endif
  output logic                 busy,
  output logic                 sclk,
  output logic                 mosi,
  input  logic                 miso,
  output logic [NUM_CS-1:0]    cs_n,
  output state_t               dbg_state
);

  localparam int CS_SEL_W = cs_sel_w(NUM_CS);
  localparam int EW       = $clog2(2 * DWIDTH);
  localparam logic [EW-1:0] EDGE_LAST = EW'(2 * DWIDTH - 1);

  state_t state, state_nx;

  logic                 cpol_q, cpha_q, lsb_q, last_q;
  logic [DIV_WIDTH-1:0] div_q;
  logic [DWIDTH-1:0]    tx_sh, rx_sh, rx_nx, rx_data_q;
  logic [EW-1:0]        edge_cnt;
  logic                 rx_valid_q;
  logic                 tick, lead, trail;
  logic                 accept, in_xfer, last_edge, capture, shift_en, cap_bit;

  function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_SEL_W-1:0] sel);
    cs_decode = '1;
    for (int i = 0; i < NUM_CS; i++)
      if (sel == CS_SEL_W'(i)) cs_decode[i] = 1'b0;
  endfunction

  assign bus.tx_ready = (state == IDLE) || (state == WAIT);
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_data  = rx_data_q;
  assign busy         = (state != IDLE);
  assign dbg_state    = state;
  assign accept       = bus.tx_valid && bus.tx_ready;
  assign in_xfer      = (state == XFER);

  spi_mc_clkgen #(.DIV_WIDTH(DIV_WIDTH)) u_clkgen (
    .clk     (clk),
    .rst     (rst),
    .en      ((state == LEAD) || in_xfer || (state == TRAIL)),
    .toggle  (in_xfer),
    .cpol    ((state == IDLE) ? cpol : cpol_q),
    .clk_div (div_q),
    .tick    (tick),
    .lead    (lead),
    .trail   (trail),
    .sclk    (sclk)
  );

`ifdef SPI_LOOPBACK_EN
  logic lb_q;
  assign cap_bit = lb_q ? mosi : miso;
`else
  assign cap_bit = miso;
`endif

  assign mosi      = lsb_q ? tx_sh[0] : tx_sh[DWIDTH-1];
  assign last_edge = in_xfer && tick && (edge_cnt == EDGE_LAST);
  assign capture   = in_xfer && (cpha_q ? trail : lead);
  // cpha=1 presents bit 0 at accept, so the first leading edge must not shift
  assign shift_en  = in_xfer && (cpha_q ? (lead && (edge_cnt != '0)) : (trail && !last_edge));

  always_comb begin
    rx_nx = rx_sh;
    if (capture) rx_nx = lsb_q ? {cap_bit, rx_sh[DWIDTH-1:1]} : {rx_sh[DWIDTH-2:0], cap_bit};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept)    state_nx = LEAD;
      LEAD:    if (tick)      state_nx = XFER;
      XFER:    if (last_edge) state_nx = last_q ? TRAIL : WAIT;
      WAIT:    if (accept)    state_nx = XFER;
      TRAIL:   if (tick)      state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      lsb_q      <= 1'b0;
      last_q     <= 1'b0;
      div_q      <= '0;
      tx_sh      <= '0;
      rx_sh      <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      edge_cnt   <= '0;
      cs_n       <= '1;
`ifdef SPI_LOOPBACK_EN
      lb_q       <= 1'b0;
`endif
    end else begin
      rx_valid_q <= last_edge;
      if (last_edge) rx_data_q <= rx_nx;

      if (accept) begin
        tx_sh    <= bus.tx_data;
        last_q   <= bus.tx_last;
        rx_sh    <= '0;
        edge_cnt <= '0;
      end else if (in_xfer && tick) begin
        edge_cnt <= edge_cnt + 1'b1;
        rx_sh    <= rx_nx;
        if (shift_en) tx_sh <= lsb_q ? (tx_sh >> 1) : (tx_sh << 1);
      end

      // Frame configuration is taken only on the first word of a frame
      if (accept && (state == IDLE)) begin
        cpol_q <= cpol;
        cpha_q <= cpha;
        lsb_q  <= lsb_first;
        div_q  <= clk_div;
`ifdef SPI_LOOPBACK_EN
        lb_q   <= loopback;
        cs_n   <= loopback ? '1 : cs_decode(bus.cs_sel);
`else
        cs_n   <= cs_decode(bus.cs_sel);
`endif
      end else if ((state == TRAIL) && tick) begin
        cs_n <= '1;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_mc.sv
// Directed bench for spi_master_mc: a 4-CS instance plus a 3-CS instance run in lockstep,
// with a behavioural SPI slave, hand-computed expectations and immediate assertions.
module tb_spi_master_mc;
  import spi_mc_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpol, cpha, lsb_first, miso;
  logic [7:0] clk_div;
  logic       busy, sclk, mosi, busy3, sclk3, mosi3;
  logic [3:0] cs_n;
  logic [2:0] cs_n3;
  state_t     dbg_state, st3;

  spi_master_mc_if #(.DWIDTH(8), .NUM_CS(4)) bus ();
  spi_master_mc_if #(.DWIDTH(8), .NUM_CS(3)) bus3 ();

  assign bus3.tx_valid = bus.tx_valid;
  assign bus3.tx_data  = bus.tx_data;
  assign bus3.tx_last  = bus.tx_last;
  assign bus3.cs_sel   = bus.cs_sel;

  spi_master_mc #(.DWIDTH(8), .NUM_CS(4), .DIV_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .bus(bus), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
    .clk_div(clk_div),
`ifdef SPI_LOOPBACK_EN
    .loopback(1'b0),
`endif
    .busy(busy), .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n), .dbg_state(dbg_state)
  );

  spi_master_mc #(.DWIDTH(8), .NUM_CS(3), .DIV_WIDTH(8)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
    .clk_div(clk_div),
`ifdef SPI_LOOPBACK_EN
    .loopback(1'b0),
`endif
    .busy(busy3), .sclk(sclk3), .mosi(mosi3), .miso(miso), .cs_n(cs_n3), .dbg_state(st3)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- monitors ----------------
  int         rxv_cnt = 0, rxv3_cnt = 0, cs3_low = 0, cs_bad = 0, lock_bad = 0;
  int         lead_cyc = 0, trail_cyc = 0, xfer_lo = 0;
  logic [7:0] rx_log [0:63];

  always @(negedge clk) begin
    if (bus.rx_valid) begin
      rx_log[rxv_cnt % 64] = bus.rx_data;
      rxv_cnt++;
    end
    if (bus3.rx_valid) rxv3_cnt++;
    if (cs_n3 !== 3'b111) cs3_low++;
    if (busy && cs_n !== 4'b1011) cs_bad++;
    if (dbg_state == LEAD) lead_cyc++;
    if (dbg_state == TRAIL) trail_cyc++;
    if (dbg_state == XFER && sclk == 1'b0) xfer_lo++;
    if (sclk3 !== sclk || mosi3 !== mosi || busy3 !== busy || st3 !== dbg_state ||
        bus3.tx_ready !== bus.tx_ready) lock_bad++;
  end

  // ---------------- scoreboard ----------------
  int vecs = 0, miscompares = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural slave ----------------
  logic       slv_on = 1'b0, s_cpha = 1'b0, s_lsb = 1'b0;
  logic [7:0] s_word = '0, s_rx = '0;
  int         s_edges = 0, s_bit = 0;
  logic [7:0] s_q[$];

  function automatic logic sbit(input logic [7:0] w, input int i, input logic lsb);
    return lsb ? w[i] : w[7-i];
  endfunction

  task automatic slave_loop();
    forever begin
      @(sclk);
      if (slv_on) begin
        s_edges++;
        if (s_cpha ? (s_edges % 2 == 0) : (s_edges % 2 == 1))
          s_rx = s_lsb ? {mosi, s_rx[7:1]} : {s_rx[6:0], mosi};
        if (s_edges == 16) begin
          got_q.push_back(s_rx);
          s_rx = '0; s_edges = 0; s_bit = 0;
          if (s_q.size() > 0) s_word = s_q.pop_front();
          miso = sbit(s_word, 0, s_lsb);
        end else if (s_cpha ? (s_edges % 2 == 1 && s_edges > 1) : (s_edges % 2 == 0)) begin
          s_bit++;
          miso = sbit(s_word, s_bit, s_lsb);
        end
      end
    end
  endtask

  task automatic start_slave(input logic [7:0] w);
    s_word = w; s_cpha = cpha; s_lsb = lsb_first;
    s_edges = 0; s_bit = 0; s_rx = '0;
    got_q.delete();
    miso = sbit(w, 0, lsb_first);
    slv_on = 1'b1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic push(input logic [7:0] d, input logic last, output int acc);
    int n = 0;
    @(negedge clk);
    bus.tx_valid = 1'b1; bus.tx_data = d; bus.tx_last = last;
    while (!bus.tx_ready && n < 500) begin @(negedge clk); n++; end
    check("accept_ready", bus.tx_ready, 1'b1);
    @(posedge clk); #1;
    acc = cyc;
    bus.tx_valid = 1'b0;
  endtask

  task automatic wait_idle(output int idl);
    int n = 0;
    while (busy && n < 5000) begin @(negedge clk); n++; end
    check("idle_reached", busy, 1'b0);
    idl = cyc;
  endtask

  task automatic set_cfg(input logic [1:0] mode, input logic lsb, input logic [7:0] div);
    @(negedge clk);
    {cpol, cpha} = mode; lsb_first = lsb; clk_div = div;
    @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  int acc, idl, rxv0, rxv30, cs30, csb0, l0, t0, xl0;

  initial begin
    rst = 1'b1; cpol = 0; cpha = 0; lsb_first = 0; clk_div = '0; miso = 0;
    bus.tx_valid = 0; bus.tx_data = '0; bus.tx_last = 0; bus.cs_sel = '0;
    fork slave_loop(); join_none
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx_ready", bus.tx_ready, 1'b1);
    check("rst_rx_valid", bus.rx_valid, 1'b0);
    check("rst_rx_data", bus.rx_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_sclk", sclk, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    check("rst_cs_n", cs_n, 4'hF);
    check("rst_state", dbg_state, IDLE);
    rst = 1'b0;

    // Mode 0, div 0, MSB first: A5 out, 3C in, 19 cycles including the accept cycle
    set_cfg(SPI_MODE0, 1'b0, 8'd0);
    bus.cs_sel = 2'd0;
    rxv0 = rxv_cnt;
    start_slave(8'h3C);
    push(8'hA5, 1'b1, acc);
    check("m0_cs_n", cs_n, 4'b1110);
    check("m0_first_mosi", mosi, 1'b1);
    wait_idle(idl);
    slv_on = 1'b0;
    check("m0_latency", idl - acc + 1, 19);
    check("m0_rx_data", bus.rx_data, 8'h3C);
    check("m0_rx_pulses", rxv_cnt - rxv0, 1);
    check("m0_mosi_word", (got_q.size() == 1) ? got_q[0] : 8'hXX, 8'hA5);
    check("m0_cs_release", cs_n, 4'hF);

    // Mode 3, div 3: idle high, LEAD/TRAIL 4 cycles, low halves 8 x 4 cycles
    set_cfg(SPI_MODE3, 1'b0, 8'd3);
    check("m3_idle_sclk", sclk, 1'b1);
    l0 = lead_cyc; t0 = trail_cyc; xl0 = xfer_lo;
    start_slave(8'hC3);
    push(8'h81, 1'b1, acc);
    wait_idle(idl);
    slv_on = 1'b0;
    check("m3_latency", idl - acc + 1, 73);
    check("m3_lead_cycles", lead_cyc - l0, 4);
    check("m3_trail_cycles", trail_cyc - t0, 4);
    check("m3_low_cycles", xfer_lo - xl0, 32);
    check("m3_rx_data", bus.rx_data, 8'hC3);
    check("m3_mosi_word", (got_q.size() == 1) ? got_q[0] : 8'hXX, 8'h81);
    check("m3_idle_sclk_after", sclk, 1'b1);

    // Mode 1, LSB first: 01 out (first bit 1), 80 in
    set_cfg(SPI_MODE1, 1'b1, 8'd1);
    start_slave(8'h80);
    push(8'h01, 1'b1, acc);
    check("lsb_first_mosi", mosi, 1'b1);
    wait_idle(idl);
    slv_on = 1'b0;
    check("lsb_rx_data", bus.rx_data, 8'h80);
    check("lsb_mosi_word", (got_q.size() == 1) ? got_q[0] : 8'hXX, 8'h01);

    // Three-word frame on CS 2 with a 10-cycle gap; cs_sel change mid-frame ignored
    set_cfg(SPI_MODE0, 1'b0, 8'd0);
    bus.cs_sel = 2'd2;
    rxv0 = rxv_cnt; csb0 = cs_bad;
    exp_q = '{8'h11, 8'h22, 8'h33};
    start_slave(8'h11);
    s_q = '{8'h22, 8'h33};
    push(8'hC1, 1'b0, acc);
    bus.cs_sel = 2'd1;
    for (int n = 0; n < 200 && dbg_state != WAIT; n++) @(negedge clk);
    repeat (10) @(negedge clk);
    check("mw_wait_state", dbg_state, WAIT);
    check("mw_wait_cs_n", cs_n, 4'b1011);
    check("mw_wait_sclk", sclk, 1'b0);
    push(8'hC2, 1'b0, acc);
    push(8'hC3, 1'b1, acc);
    wait_idle(idl);
    slv_on = 1'b0;
    check("mw_rx_pulses", rxv_cnt - rxv0, 3);
    for (int k = 0; k < 3; k++) check("mw_rx_word", rx_log[(rxv0 + k) % 64], exp_q[k]);
    check("mw_mosi_words", got_q.size(), 3);
    check("mw_mosi_w0", (got_q.size() > 0) ? got_q[0] : 8'hXX, 8'hC1);
    check("mw_mosi_w2", (got_q.size() > 2) ? got_q[2] : 8'hXX, 8'hC3);
    check("mw_cs_hold", cs_bad - csb0, 0);
    check("mw_cs_release", cs_n, 4'hF);

    // Reset at the start of bit 4 of a div-1 transfer
    set_cfg(SPI_MODE0, 1'b0, 8'd1);
    bus.cs_sel = 2'd0;
    start_slave(8'h96);
    push(8'h5B, 1'b1, acc);
    repeat (19) @(negedge clk);
    check("rst_mid_in_xfer", dbg_state, XFER);
    rxv0 = rxv_cnt;
    slv_on = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_cs_n", cs_n, 4'hF);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_rx_valid", bus.rx_valid, 1'b0);
    check("rst_mid_sclk", sclk, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("rst_mid_no_rx", rxv_cnt - rxv0, 0);
    check("rst_mid_rx_data", bus.rx_data, 8'h00);
    start_slave(8'h69);
    push(8'hE7, 1'b1, acc);
    wait_idle(idl);
    slv_on = 1'b0;
    check("post_rst_rx_data", bus.rx_data, 8'h69);
    check("post_rst_mosi_word", (got_q.size() == 1) ? got_q[0] : 8'hXX, 8'hE7);

    // cs_sel=3 on the 3-CS instance selects nothing but still transfers
    set_cfg(SPI_MODE0, 1'b0, 8'd0);
    bus.cs_sel = 2'd3;
    cs30 = cs3_low; rxv30 = rxv3_cnt;
    start_slave(8'hD2);
    push(8'h3A, 1'b1, acc);
    check("cs3_dut4_cs_n", cs_n, 4'b0111);
    check("cs3_dut3_cs_n", cs_n3, 3'b111);
    wait_idle(idl);
    slv_on = 1'b0;
    check("cs3_no_cs", cs3_low - cs30, 0);
    check("cs3_rx_pulses", rxv3_cnt - rxv30, 1);
    check("cs3_rx_data", bus3.rx_data, 8'hD2);
    check("lockstep", lock_bad, 0);

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
